// File: rtl/seq_median_sorter_if.sv
// Handshake bundle for the sequential median sorter: a sample input stream
// and a sorted output stream with the frame median alongside.
interface seq_median_sorter_if #(
  parameter int WIDTH = 6
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_num;
  logic             in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_num;
  logic [WIDTH-1:0] out_median;
  logic             out_last;

  // Sample source / result sink side
  modport master (
    output in_valid, in_num, in_mode, out_ready,
    input  in_ready, out_valid, out_num, out_median, out_last
  );

  // Sorter side
  modport slave (
    input  in_valid, in_num, in_mode, out_ready,
    output in_ready, out_valid, out_num, out_median, out_last
  );
endinterface

// File: rtl/seq_median_sorter.sv
// Sequential median sorter: collects DEPTH samples, insertion-sorting each one
// on arrival, then streams the sorted frame (ascending or descending) while
// presenting the median.
module seq_median_sorter #(
  parameter  int WIDTH = 6,
  parameter  int DEPTH = 5,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  seq_median_sorter_if.slave bus
);

  localparam int MED_IDX = (DEPTH - 1) / 2;

  typedef enum logic {COLLECT, OUTPUT} state_t;

  state_t                       state_reg, state_next;
  logic [CNT_W-1:0]             count_reg;
  logic [CNT_W-1:0]             out_idx_reg;
  logic                         mode_q_reg;
  logic [DEPTH-1:0][WIDTH-1:0]  sort_buf_reg;
  logic [DEPTH-1:0][WIDTH-1:0]  sort_buf_next;
  logic [DEPTH-1:0]             gt;
  logic [CNT_W-1:0]             rd_idx;
  logic                         accept;
  logic                         out_fire;
  logic                         is_last;

  assign accept   = bus.in_valid && (state_reg == COLLECT);
  assign out_fire = (state_reg == OUTPUT) && bus.out_ready;
  assign is_last  = (out_idx_reg == CNT_W'(DEPTH - 1));

  // Parallel compare-and-shift insertion. gt marks occupied entries strictly
  // greater than the new sample; since the buffer is ascending, gt is a
  // contiguous run from the insertion point upward, and equal entries stay
  // below the new value so ties keep arrival order.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_ins
      assign gt[gi] = (CNT_W'(gi) < count_reg) && (sort_buf_reg[gi] > bus.in_num);
      if (gi == 0) begin : g_first
        assign sort_buf_next[gi] = ((count_reg != '0) && !gt[gi]) ? sort_buf_reg[gi]
                                                                  : bus.in_num;
      end else begin : g_rest
        assign sort_buf_next[gi] =
          (((CNT_W'(gi) < count_reg) && !gt[gi]) || (CNT_W'(gi) > count_reg)) ? sort_buf_reg[gi] :
          (!gt[gi-1])                                                         ? bus.in_num :
                                                                                sort_buf_reg[gi-1];
      end
    end
  endgenerate

  // Descending order simply reads the ascending buffer from the top.
  assign rd_idx = mode_q_reg ? (CNT_W'(DEPTH - 1) - out_idx_reg) : out_idx_reg;

  assign bus.in_ready   = (state_reg == COLLECT);
  assign bus.out_valid  = (state_reg == OUTPUT);
  assign bus.out_num    = (state_reg == OUTPUT) ? sort_buf_reg[rd_idx]  : '0;
  assign bus.out_median = (state_reg == OUTPUT) ? sort_buf_reg[MED_IDX] : '0;
  assign bus.out_last   = (state_reg == OUTPUT) && is_last;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= COLLECT;
    else     state_reg <= state_next;
  end

  // Next-state decode: full frame -> OUTPUT, last output handshake -> COLLECT
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      COLLECT: if (accept && (count_reg == CNT_W'(DEPTH - 1))) state_next = OUTPUT;
      OUTPUT:  if (out_fire && is_last) state_next = COLLECT;
      default: state_next = COLLECT;
    endcase
  end

  // Datapath: buffer insertion, counters and captured output order
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg    <= '0;
      out_idx_reg  <= '0;
      mode_q_reg   <= 1'b0;
      sort_buf_reg <= '0;
    end else if (accept) begin
      sort_buf_reg <= sort_buf_next;
      count_reg    <= count_reg + CNT_W'(1);
      if (count_reg == '0) mode_q_reg <= bus.in_mode;
    end else if (out_fire) begin
      if (is_last) begin
        out_idx_reg <= '0;
        count_reg   <= '0;
      end else begin
        out_idx_reg <= out_idx_reg + CNT_W'(1);
      end
    end
  end

endmodule
